// File: rtl/mux_nx1_rr_if.sv
// ---------------------------------------------------------------------------
// mux_nx1_rr_if : handshake/data bundle for the N:1 registered mux.
//
// Parameters : WIDTH (bits per channel), CHANNELS (input count),
//              SEL_W (index width, equals $clog2(CHANNELS)).
// Signals    : mode      0 = manual select, 1 = round-robin
//              sel       channel index for manual mode
//              in_data   packed inputs, channel i at [i*WIDTH +: WIDTH]
//              in_valid  per-channel valid
//              in_ready  per-channel ready (driven by the mux)
//              out_data  registered selected word
//              out_valid registered output valid
//              out_ready downstream ready
//              out_chan  channel index of the word in out_data
// Modports   : master - producer/consumer side (drives inputs, out_ready)
//              slave  - the mux itself
// ---------------------------------------------------------------------------
interface mux_nx1_rr_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SEL_W-1:0]          out_chan;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );
endinterface

// File: rtl/mux_nx1_rr.sv
// ---------------------------------------------------------------------------
// mux_nx1_rr : N-channel registered multiplexer with valid/ready handshake.
//
// Two grant modes: manual (bus.sel chooses the channel) and round-robin
// (first valid channel starting at an internal pointer). The selected word
// is captured into a single output register; a new word loads whenever the
// register is empty or being drained, giving one transfer per cycle.
//
// Ports : clk       rising-edge clock
//         rst       synchronous active-high reset
//         bus       mux_nx1_rr_if.slave (see interface header)
//         grant_cnt 8-bit wrapping count of input transfers
//                   (only when MUX_GRANT_CNT_EN is defined)
//
// Optional feature macro: MUX_GRANT_CNT_EN
// ---------------------------------------------------------------------------
module mux_nx1_rr #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic       clk,
    input  logic       rst,
`ifdef MUX_GRANT_CNT_EN
    output logic [7:0] grant_cnt,
`endif
    mux_nx1_rr_if.slave bus
);
    // Valid vector widened to every encodable index so that a manual sel
    // beyond CHANNELS-1 reads a 0 and therefore never grants.
    localparam int SEL_RANGE = 1 << SEL_W;

    logic [SEL_RANGE-1:0] valid_ext;
    logic                 load;
    logic                 grant_vld;
    logic [SEL_W-1:0]     grant;
    logic [WIDTH-1:0]     grant_data;

    logic [WIDTH-1:0]     out_data_q;
    logic                 out_valid_q;
    logic [SEL_W-1:0]     out_chan_q;
    logic [SEL_W-1:0]     ptr_q;
    logic [SEL_W-1:0]     ptr_d;

    assign load = !out_valid_q || bus.out_ready;

    // Grant selection.
    always_comb begin
        int         idx;
        logic [SEL_W-1:0] idx_sel;
        valid_ext                 = '0;
        valid_ext[CHANNELS-1:0]   = bus.in_valid;
        grant                     = '0;
        grant_vld                 = 1'b0;
        idx                       = 0;
        idx_sel                   = '0;
        if (!bus.mode) begin
            grant     = bus.sel;
            grant_vld = valid_ext[bus.sel];
        end else begin
            // Scan ptr, ptr+1, ... with explicit wrap at CHANNELS (not at
            // 2**SEL_W), keeping the first hit.
            for (int k = 0; k < CHANNELS; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= CHANNELS) begin
                    idx = idx - CHANNELS;
                end
                idx_sel = SEL_W'(idx);
                if (!grant_vld && valid_ext[idx_sel]) begin
                    grant     = idx_sel;
                    grant_vld = 1'b1;
                end
            end
        end
    end

    // Data of the granted channel only; other channels never reach the
    // output, so unknowns there cannot propagate.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_d = (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + SEL_W'(1);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
            assign bus.in_ready[gi] = !rst && load && grant_vld
                                      && (grant == SEL_W'(gi));
        end
    endgenerate

`ifdef MUX_GRANT_CNT_EN
    logic [7:0] grant_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
`ifdef MUX_GRANT_CNT_EN
            grant_cnt_q <= '0;
`endif
        end else if (load) begin
            if (grant_vld) begin
                // Input transfer on channel 'grant'.
                out_data_q  <= grant_data;
                out_chan_q  <= grant;
                out_valid_q <= 1'b1;
                if (bus.mode) begin
                    ptr_q <= ptr_d;
                end
`ifdef MUX_GRANT_CNT_EN
                grant_cnt_q <= grant_cnt_q + 8'd1;
`endif
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_chan  = out_chan_q;
`ifdef MUX_GRANT_CNT_EN
    assign grant_cnt     = grant_cnt_q;
`endif

endmodule

// File: tb/tb_mux_nx1_rr.sv
// ---------------------------------------------------------------------------
// tb_mux_nx1_rr : directed bench for mux_nx1_rr with a 4-channel and a
// 3-channel instance. Expected values are hand-derived constants.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mux_nx1_rr;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mux_nx1_rr_if #(.WIDTH(4), .CHANNELS(4), .SEL_W(2)) b4 ();
    mux_nx1_rr_if #(.WIDTH(4), .CHANNELS(3), .SEL_W(2)) b3 ();

`ifdef MUX_GRANT_CNT_EN
    logic [7:0] gc4;
    logic [7:0] gc3;
`endif

    mux_nx1_rr #(.WIDTH(4), .CHANNELS(4), .SEL_W(2)) dut4 (
        .clk       (clk),
        .rst       (rst),
`ifdef MUX_GRANT_CNT_EN
        .grant_cnt (gc4),
`endif
        .bus       (b4)
    );

    mux_nx1_rr #(.WIDTH(4), .CHANNELS(3), .SEL_W(2)) dut3 (
        .clk       (clk),
        .rst       (rst),
`ifdef MUX_GRANT_CNT_EN
        .grant_cnt (gc3),
`endif
        .bus       (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        n_checks = 0;
        n_errors = 0;

        // ---------------- reset ----------------
        rst          = 1'b1;
        b4.mode      = 1'b0;
        b4.sel       = 2'd0;
        b4.in_data   = 16'h8421;
        b4.in_valid  = 4'hF;
        b4.out_ready = 1'b1;
        b3.mode      = 1'b0;
        b3.sel       = 2'd0;
        b3.in_data   = 12'h421;
        b3.in_valid  = 3'b000;
        b3.out_ready = 1'b1;
        #1;
        check("rst_in_ready", b4.in_ready, 0);
        tick();
        tick();
        check("rst_out_valid", b4.out_valid, 0);
        check("rst_out_data", b4.out_data, 0);
        check("rst_out_chan", b4.out_chan, 0);
        check("rst_in_ready_held", b4.in_ready, 0);
`ifdef MUX_GRANT_CNT_EN
        check("rst_grant_cnt", gc4, 0);
`endif
        rst = 1'b0;

        // ---------------- 1. manual sweep ----------------
        for (int s = 0; s < 4; s++) begin
            b4.sel = 2'(s);
            #1;
            check($sformatf("man_in_ready_%0d", s), b4.in_ready, 32'(1 << s));
            tick();
            check($sformatf("man_data_%0d", s), b4.out_data, 32'(1 << s));
            check($sformatf("man_chan_%0d", s), b4.out_chan, s);
            check($sformatf("man_valid_%0d", s), b4.out_valid, 1);
        end

        // ---------------- 2. RR fairness (ptr still 0) ----------------
        b4.mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("rr_in_ready_%0d", i), b4.in_ready, 32'(1 << (i % 4)));
            tick();
            check($sformatf("rr_chan_%0d", i), b4.out_chan, i % 4);
            check($sformatf("rr_data_%0d", i), b4.out_data, 32'(1 << (i % 4)));
        end

        // ---------------- 3. RR skip / wrap ----------------
        b4.in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            c = (i % 2 == 1) ? 3 : 1;
            #1;
            check($sformatf("skip_in_ready_%0d", i), b4.in_ready, 32'(1 << c));
            tick();
            check($sformatf("skip_chan_%0d", i), b4.out_chan, c);
        end
        b4.in_valid = 4'b0001;
        #1;
        check("solo0_in_ready", b4.in_ready, 32'b0001);
        tick();
        check("solo0_chan", b4.out_chan, 0);
        check("solo0_data", b4.out_data, 32'b0001);
        // ptr must now be 1: with all valid, channel 1 wins.
        b4.in_valid = 4'b1111;
        #1;
        check("ptr1_in_ready", b4.in_ready, 32'b0010);
        tick();
        check("ptr1_chan", b4.out_chan, 1);

        // ---------------- 4. backpressure ----------------
        b4.out_ready = 1'b0;
        b4.mode      = 1'b0;
        b4.sel       = 2'd2;
        #1;
        check("bp_in_ready", b4.in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_data_%0d", i), b4.out_data, 32'b0010);
            check($sformatf("bp_chan_%0d", i), b4.out_chan, 1);
            check($sformatf("bp_valid_%0d", i), b4.out_valid, 1);
            check($sformatf("bp_in_ready_%0d", i), b4.in_ready, 0);
        end
        b4.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", b4.in_ready, 32'b0100);
        tick();
        check("bp_release_data", b4.out_data, 32'b0100);
        check("bp_release_chan", b4.out_chan, 2);

        // ---------------- 5. boundaries ----------------
        b4.sel      = 2'd3;
        b4.in_valid = 4'b0111;
        b3.mode     = 1'b0;
        b3.sel      = 2'd2;
        b3.in_valid = 3'b111;
        #1;
        check("sel3_in_ready", b4.in_ready, 0);
        tick();
        check("sel3_valid", b4.out_valid, 0);
        check("sel3_data_hold", b4.out_data, 32'b0100);
        check("sel3_chan_hold", b4.out_chan, 2);
        check("c3_load_chan", b3.out_chan, 2);
        check("c3_load_valid", b3.out_valid, 1);
        b3.sel = 2'd3;
        #1;
        check("c3_sel3_in_ready", b3.in_ready, 0);
        tick();
        check("c3_sel3_valid", b3.out_valid, 0);
        b3.mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c = i % 3;
            #1;
            check($sformatf("c3_rr_in_ready_%0d", i), b3.in_ready, 32'(1 << c));
            tick();
            check($sformatf("c3_rr_chan_%0d", i), b3.out_chan, c);
            check($sformatf("c3_rr_data_%0d", i), b3.out_data, 32'(1 << c));
        end

        // ---------------- 6. reset mid-stream ----------------
        // dut4 ptr is 2 from the RR traffic above.
        b4.mode     = 1'b1;
        b4.in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            c = (i + 2) % 4;
            tick();
            check($sformatf("pre_rst_chan_%0d", i), b4.out_chan, c);
        end
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", b4.in_ready, 0);
        tick();
        check("mid_rst_valid", b4.out_valid, 0);
        check("mid_rst_data", b4.out_data, 0);
        check("mid_rst_chan", b4.out_chan, 0);
        check("mid_rst_c3_valid", b3.out_valid, 0);
`ifdef MUX_GRANT_CNT_EN
        check("mid_rst_grant_cnt", gc4, 0);
`endif
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", b4.in_ready, 32'b0001);
        check("post_rst_c3_in_ready", b3.in_ready, 32'b001);
        tick();
        check("post_rst_chan", b4.out_chan, 0);
        check("post_rst_data", b4.out_data, 32'b0001);
`ifdef MUX_GRANT_CNT_EN
        check("cnt_first", gc4, 1);
        for (int i = 0; i < 254; i++) begin
            tick();
        end
        check("cnt_255", gc4, 255);
        tick();
        check("cnt_wrap", gc4, 0);
`endif

        // ---------------- unknowns on non-granted channels ----------------
        b4.mode     = 1'b0;
        b4.sel      = 2'd1;
        b4.in_data  = {4'b1000, 4'b0100, 4'b0010, 4'bxxxx};
        b4.in_valid = 4'b111x;
        #1;
        check("x_in_ready", b4.in_ready, 32'b0010);
        tick();
        check("x_data", b4.out_data, 32'b0010);
        check("x_chan", b4.out_chan, 1);
        check("x_valid", b4.out_valid, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
